// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO that feeds a UART transmitter from a CPU write port.
// Define UART_TX_FIFO_OVF_EN to add the sticky overflow flag (ovf_flag) and its clear strobe (ovf_clr).
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_wr_en,
  input  logic [7:0]               cpu_wr_data,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
`ifdef UART_TX_FIFO_OVF_EN
  output logic                     ovf_flag,
  input  logic                     ovf_clr,
`endif
  input  logic                     tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;

  logic          w_push;
  logic          w_pop;

  // Status and head byte decode from registered state only.
  always_comb begin
    fifo_full  = (r_level == LW'(DEPTH));
    fifo_empty = (r_level == '0);
    fifo_level = r_level;
    tx_valid   = ~fifo_empty;
    tx_data    = fifo_empty ? 8'h00 : r_mem[r_rd_ptr];
  end

  assign w_push = cpu_wr_en & ~fifo_full;
  assign w_pop  = tx_valid & tx_ready;

  // Storage is not reset; the empty decode above masks stale entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= cpu_wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  // A dropped write wins over a coincident clear so no overflow goes unreported.
  always_ff @(posedge clk) begin
    if (rst)                         ovf_flag <= 1'b0;
    else if (cpu_wr_en && fifo_full) ovf_flag <= 1'b1;
    else if (ovf_clr)                ovf_flag <= 1'b0;
  end
`endif

endmodule
